// File: rtl/stream_packer.sv
// Packs IN_WIDTH-bit AXI4-Stream samples into OUT_WIDTH-bit words; tlast flushes a partial word with tkeep lane marking.
// Define STREAM_PACKER_MSB_FIRST_EN to place the first sample of a word in the MSB lane.
module stream_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [IN_WIDTH-1:0]             s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [OUT_WIDTH-1:0]            m_axis_tdata,
  output logic [OUT_WIDTH/IN_WIDTH-1:0]   m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready
);

  localparam int N  = OUT_WIDTH / IN_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((OUT_WIDTH % IN_WIDTH) != 0 || N < 2) begin : g_bad_width
      $error("stream_packer: OUT_WIDTH must be a multiple of IN_WIDTH with ratio >= 2");
    end
  endgenerate

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovld_q, ovld_d;
  logic [OUT_WIDTH-1:0] odata_q, odata_d;
  logic [N-1:0]         okeep_q, okeep_d;
  logic                 olast_q, olast_d;

  logic                 accept;
  logic                 completing;
  logic [CW-1:0]        lane;
  logic [OUT_WIDTH-1:0] merged;
  logic [N-1:0]         keep_new;

  assign s_axis_tready = aresetn && (!ovld_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign completing    = (cnt_q == CW'(N - 1)) || s_axis_tlast;

  always_comb begin
    lane     = '0;
    merged   = acc_q;
    keep_new = '0;
`ifdef STREAM_PACKER_MSB_FIRST_EN
    lane = CW'(N - 1) - cnt_q;
`else
    lane = cnt_q;
`endif
    // acc lanes past cnt are always zero, so merging leaves the upper lanes cleared
    for (int k = 0; k < N; k++) begin
      if (lane == CW'(k)) merged[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
`ifdef STREAM_PACKER_MSB_FIRST_EN
      keep_new[N-1-k] = (CW'(k) <= cnt_q);
`else
      keep_new[k] = (CW'(k) <= cnt_q);
`endif
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovld_d  = ovld_q;
    odata_d = odata_q;
    okeep_d = okeep_q;
    olast_d = olast_q;
    if (ovld_q && m_axis_tready) ovld_d = 1'b0;
    if (accept) begin
      if (completing) begin
        odata_d = merged;
        okeep_d = keep_new;
        olast_d = s_axis_tlast;
        ovld_d  = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
      okeep_q <= '0;
      olast_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovld_q  <= ovld_d;
      odata_q <= odata_d;
      okeep_q <= okeep_d;
      olast_q <= olast_d;
    end
  end

  assign m_axis_tdata  = odata_q;
  assign m_axis_tkeep  = okeep_q;
  assign m_axis_tlast  = olast_q;
  assign m_axis_tvalid = ovld_q;

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer (IN=8, OUT=32): per-cycle scoreboard against a sample-queue model plus directed word checks.
module tb_stream_packer;

  localparam int IW = 8;
  localparam int OW = 32;
  localparam int N  = OW / IW;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [IW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [OW-1:0] m_data;
  logic [N-1:0]  m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;

  stream_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tkeep  (m_keep),
    .m_axis_tlast  (m_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready)
  );

  always #5 aclk = ~aclk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int stall_cycles = 0;

  // Model: samples of the word being built, plus the one held output word.
  logic [IW-1:0] part[$];
  logic          mv = 1'b0;
  logic [OW-1:0] md = '0;
  logic [N-1:0]  mk = '0;
  logic          ml = 1'b0;

  logic [63:0]   got[$];

  function automatic logic [63:0] w(input logic l, input logic [N-1:0] k, input logic [OW-1:0] d);
    return 64'({l, k, d});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [63:0] exp);
    chk(nm, (idx < got.size()) ? got[idx] : 64'hFFFF_FFFF_FFFF_FFFF, exp);
  endtask

  task automatic send(input logic [IW-1:0] d, input logic l);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge aclk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    repeat (4) @(posedge aclk);
    #1;
  endtask

  // Reference model and output logger, evaluated on pre-edge values.
  initial begin
    forever begin
      @(posedge aclk);
      cyc++;
      if (aresetn && m_valid && m_ready) got.push_back(w(m_last, m_keep, m_data));
      if (!aresetn) begin
        part.delete();
        mv = 1'b0;
      end else begin
        bit rdy;
        rdy = !mv || m_ready;
        if (mv && m_ready) mv = 1'b0;
        if (s_valid && rdy) begin
          part.push_back(s_data);
          if (part.size() == N || s_last) begin
            md = '0;
            mk = '0;
            for (int i = 0; i < part.size(); i++) begin
              int ln;
`ifdef STREAM_PACKER_MSB_FIRST_EN
              ln = N - 1 - i;
`else
              ln = i;
`endif
              md[ln*IW +: IW] = part[i];
              mk[ln] = 1'b1;
            end
            ml = s_last;
            mv = 1'b1;
            part.delete();
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        chk("rst_tready", 64'(s_ready), 64'd0);
        chk("rst_tvalid", 64'(m_valid), 64'd0);
        chk("rst_word", w(m_last, m_keep, m_data), 64'd0);
      end else begin
        if (!s_ready) stall_cycles++;
        chk("tready", 64'(s_ready), 64'(!mv || m_ready));
        chk("tvalid", 64'(m_valid), 64'(mv));
        if (mv) chk("word", w(m_last, m_keep, m_data), w(ml, mk, md));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int st0;
    bit done;
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    chk("tready_after_reset", 64'(s_ready), 64'd1);

    // Full word, one cycle latency
    got.delete();
`ifdef STREAM_PACKER_MSB_FIRST_EN
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
`else
    send(8'h44, 0); send(8'h33, 0); send(8'h22, 0); send(8'h11, 0);
`endif
    chk("full_latency_tvalid", 64'(m_valid), 64'd1);
    drain();
    chk("full_count", 64'(got.size()), 64'd1);
    chk_got("full_word", 0, w(1'b0, 4'hF, 32'h1122_3344));

    // Partial frame, then the next sample restarts at the first lane
    got.delete();
    send(8'hAA, 0); send(8'hBB, 1);
    send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0); send(8'hFF, 0);
    drain();
    chk("partial_count", 64'(got.size()), 64'd2);
`ifdef STREAM_PACKER_MSB_FIRST_EN
    chk_got("partial_word", 0, w(1'b1, 4'hC, 32'hAABB_0000));
    chk_got("after_partial", 1, w(1'b0, 4'hF, 32'hCCDD_EEFF));
    got.delete();
    send(8'hAA, 1);
    drain();
    chk_got("msb_single", 0, w(1'b1, 4'h8, 32'hAA00_0000));
`else
    chk_got("partial_word", 0, w(1'b1, 4'h3, 32'h0000_BBAA));
    chk_got("after_partial", 1, w(1'b0, 4'hF, 32'hFFEE_DDCC));
    got.delete();
    send(8'h5A, 1);
    drain();
    chk_got("single_lane", 0, w(1'b1, 4'h1, 32'h0000_005A));
    got.delete();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 1);
    drain();
    chk("last_on_nth_count", 64'(got.size()), 64'd1);
    chk_got("last_on_nth", 0, w(1'b1, 4'hF, 32'h0403_0201));
`endif

    // Backpressure: downstream stalls for five cycles mid-stream
    got.delete();
    st0 = stall_cycles;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(8'(i), 0);
      end
      begin
        repeat (4) @(posedge aclk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge aclk);
        #1 m_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 64'(got.size()), 64'd3);
`ifndef STREAM_PACKER_MSB_FIRST_EN
    chk_got("bp_word0", 0, w(1'b0, 4'hF, 32'h0403_0201));
    chk_got("bp_word1", 1, w(1'b0, 4'hF, 32'h0807_0605));
    chk_got("bp_word2", 2, w(1'b0, 4'hF, 32'h0C0B_0A09));
`endif
    chk("bp_stall_seen", 64'(stall_cycles > st0), 64'd1);

    // Reset mid-word discards the partial accumulation
    send(8'h11, 0); send(8'h22, 0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    got.delete();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    drain();
    chk("rst_mid_count", 64'(got.size()), 64'd1);
`ifndef STREAM_PACKER_MSB_FIRST_EN
    chk_got("rst_mid_word", 0, w(1'b0, 4'hF, 32'h0403_0201));
`endif

    // Full-rate throughput: 16 samples in 16 cycles
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 0);
    chk("throughput_cycles", 64'(cyc - c0), 64'd16);
    drain();

    // Random data and random downstream readiness, tlast every 7th sample
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) send(8'($urandom), (i % 7) == 6);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge aclk);
          #1 m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_packer.md
# stream_packer

- Packs a stream of narrow samples into full-width words: the sequential inverse of the bit-field splitter used elsewhere in the datapath.
- Accepts `IN_WIDTH`-bit samples on an AXI4-Stream slave port and emits `OUT_WIDTH`-bit words on an AXI4-Stream master port.
- Sits between per-symbol/per-subcarrier producers in the OFDM modem and wide consumers: DMA, FIFOs, AXI-Lite-visible buffers.
- Handles frame boundaries via `tlast`: a partial word is flushed with lane-valid marking.

## Interface

Parameters:
- `IN_WIDTH`, 8: sample (lane) width in bits.
- `OUT_WIDTH`, 32: output word width. Must be an integer multiple of `IN_WIDTH`, with `N = OUT_WIDTH/IN_WIDTH` ≥ 2. Any other value is a compile-time error.

Ports:
- `aclk`  in  1: the only clock. All logic is rising-edge.
- `aresetn`  in  1: reset, asynchronous assert, active-low.
- `s_axis_tdata`  in  `IN_WIDTH`: input sample.
- `s_axis_tvalid`  in  1: input sample valid.
- `s_axis_tlast`  in  1: last sample of frame.
- `s_axis_tready`  out  1: block accepts input.
- `m_axis_tdata`  out  `OUT_WIDTH`: packed word.
- `m_axis_tkeep`  out  `N`: one bit per lane; 1 = lane holds a real sample.
- `m_axis_tlast`  out  1: word closes a frame.
- `m_axis_tvalid`  out  1: output word valid.
- `m_axis_tready`  in  1: downstream accepts.

## Operation

- **State:**
  - accumulation register `acc` (`OUT_WIDTH` bits)
  - lane counter `cnt` (0..N-1, width `$clog2(N)`)
  - output holding register with valid flag `ovld`
- **Input handshake:**
  - A beat transfers when `s_axis_tvalid && s_axis_tready`.
  - `s_axis_tready = aresetn && (!ovld || m_axis_tready)`.
  - Does not depend on `s_axis_tvalid`.
- **Lane placement:** the sample accepted at `cnt = k` occupies bits `[k*IN_WIDTH +: IN_WIDTH]`. Lane 0 is the LSBs (default order).
- **Non-completing beat** (`cnt < N-1` and `!tlast`):
  - sample written into `acc` lane `cnt`
  - `cnt` incremented
- **Completing beat** (`cnt == N-1`, or `tlast == 1`):
  - output register loaded with `acc` merged with the new sample; lanes above `cnt` forced to 0
  - `m_axis_tkeep` set to bits `[cnt:0]` = 1
  - `m_axis_tlast` = input `tlast`
  - `ovld` set
  - `acc` cleared, `cnt` set to 0
- **Output handshake:**
  - `ovld` clears on `m_axis_tvalid && m_axis_tready`, unless a completing beat reloads it in the same cycle.
  - `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` stay stable while `m_axis_tvalid && !m_axis_tready`.
- **tlast on the Nth lane:** full word, `tkeep` all ones, `tlast` = 1. No extra empty word is generated.
- **tlast at `cnt = 0`:** single-lane word, `tkeep = 1`.

## Timing

- **Reset values:** all of the following are 0, and `s_axis_tready` is 0 while `aresetn` is low:
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`
  - `cnt`, `acc`
- **After reset release:** `s_axis_tready` = 1 combinationally.
- **Latency:** a completing beat accepted at edge *t* gives `m_axis_tvalid` = 1 after edge *t*. Packing adds one cycle.
- **Throughput:** with `m_axis_tready` held 1, one sample per cycle is sustained indefinitely, producing one word every N cycles.
- **Backpressure:** while `ovld && !m_axis_tready`, `s_axis_tready` = 0 and no sample is lost or duplicated. This also stalls non-completing beats (deliberately simple).
- **Reset mid-word:** the partial `acc` and the pending output word are discarded. The first sample after reset lands in lane 0.

## Configuration

- **Macro:** `STREAM_PACKER_MSB_FIRST_EN`.
- **Defined:**
  - Lane order is reversed: sample at `cnt = k` goes to lane `N-1-k`, i.e. the first sample in the MSBs.
  - `m_axis_tkeep` bit order is reversed to match: partial words are left-aligned with zeros in the LSB lanes.
- **Undefined (default):** LSB-first order as in Operation.

## Test plan

- **Full word:** IN=8, OUT=32, `m_axis_tready` = 1; samples 0x44, 0x33, 0x22, 0x11, no `tlast` -> one word 0x11223344, `tkeep` = 0xF, `tlast` = 0, one cycle after the 4th accept.
- **Partial frame:** 0xAA, 0xBB with `tlast` on 0xBB -> 0x0000BBAA, `tkeep` = 0x3, `tlast` = 1. The next sample 0xCC lands in lane 0.
- **Backpressure:** 12 continuous samples 0x01..0x0C; `m_axis_tready` low for cycles 5-9 -> exactly three words: 0x04030201, 0x08070605, 0x0C0B0A09. Data is stable during the stall and `s_axis_tready` drops while the output is held.
- **Reset mid-word:** accept 0x11, 0x22; assert `aresetn` low for 2 cycles; then feed 0x01..0x04 -> all outputs 0 during reset, then a single word 0x04030201.
- **Steady state:** 64 random samples, `tlast` every 7th sample, random `m_axis_tready` -> scoreboard matches a reference packing model. Full-rate periods show 100% input utilisation.
- **`STREAM_PACKER_MSB_FIRST_EN` defined:**
  - samples 0x11, 0x22, 0x33, 0x44 -> 0x11223344
  - 0xAA with `tlast` -> 0xAA000000, `tkeep` = 0x8
